// File: rtl/quadrature_debouncer_if.sv
// Encoder-side bundle: raw pins and tick in, clean levels and violation status out.
interface quadrature_debouncer_if #(
  parameter int unsigned ERR_WIDTH = 8
);

  logic                 sample_tick;
  logic                 a_raw;
  logic                 b_raw;
  logic                 a;
  logic                 b;
  logic                 illegal;
  logic [ERR_WIDTH-1:0] err_count;

  // Upstream driver of the raw pins; reads back the conditioned levels.
  modport master (
    output sample_tick,
    output a_raw,
    output b_raw,
    input  a,
    input  b,
    input  illegal,
    input  err_count
  );

  // The debouncer itself.
  modport slave (
    input  sample_tick,
    input  a_raw,
    input  b_raw,
    output a,
    output b,
    output illegal,
    output err_count
  );

endinterface

// File: rtl/quadrature_debouncer.sv
// Quadrature encoder input conditioner: per-channel synchronizer and debounce,
// plus detection and saturating count of same-edge A/B changes.
module quadrature_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned ERR_WIDTH       = 8
) (
  input logic                   clk,
  input logic                   reset,
  quadrature_debouncer_if.slave bus
);

  // Terminal count: a new level is accepted on the tick that finds the counter here.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX  = {ERR_WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic                   sa;
  logic                   sb;

  logic [CNT_WIDTH-1:0]   cnt_a;
  logic [CNT_WIDTH-1:0]   cnt_b;
  logic [CNT_WIDTH-1:0]   cnt_a_next;
  logic [CNT_WIDTH-1:0]   cnt_b_next;

  logic                   a_q;
  logic                   b_q;
  logic                   a_next;
  logic                   b_next;

  logic                   illegal_q;
  logic                   illegal_next;
  logic [ERR_WIDTH-1:0]   err_q;
  logic [ERR_WIDTH-1:0]   err_next;

  // Metastability chains; they shift every clock independent of sample_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.a_raw};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.b_raw};
    end
  end

  assign sa = sync_a[SYNC_STAGES-1];
  assign sb = sync_b[SYNC_STAGES-1];

  // Channel A qualification: any tick agreeing with the current level restarts it.
  always_comb begin
    a_next     = a_q;
    cnt_a_next = cnt_a;
    if (bus.sample_tick) begin
      if (sa == a_q) begin
        cnt_a_next = '0;
      end else if (cnt_a == CNT_LAST) begin
        a_next     = sa;
        cnt_a_next = '0;
      end else begin
        cnt_a_next = cnt_a + CNT_WIDTH'(1);
      end
    end
  end

  // Channel B qualification, independent of A.
  always_comb begin
    b_next     = b_q;
    cnt_b_next = cnt_b;
    if (bus.sample_tick) begin
      if (sb == b_q) begin
        cnt_b_next = '0;
      end else if (cnt_b == CNT_LAST) begin
        b_next     = sb;
        cnt_b_next = '0;
      end else begin
        cnt_b_next = cnt_b + CNT_WIDTH'(1);
      end
    end
  end

  // A violation is both accepted levels flipping on the same edge; count saturates.
  always_comb begin
    illegal_next = (a_next != a_q) && (b_next != b_q);
    err_next     = err_q;
    if (illegal_next && (err_q != ERR_MAX)) begin
      err_next = err_q + ERR_WIDTH'(1);
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_a     <= '0;
      cnt_b     <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= '0;
    end else begin
      cnt_a     <= cnt_a_next;
      cnt_b     <= cnt_b_next;
      a_q       <= a_next;
      b_q       <= b_next;
      illegal_q <= illegal_next;
      err_q     <= err_next;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.illegal   = illegal_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_quadrature_debouncer.sv
// Directed bench for quadrature_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ERR_WIDTH=2.
module tb_quadrature_debouncer;

  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned CNT_WIDTH       = 16;
  localparam int unsigned ERR_WIDTH       = 2;
  localparam int unsigned LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  quadrature_debouncer_if #(.ERR_WIDTH(ERR_WIDTH)) bus ();

  quadrature_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH),
    .ERR_WIDTH      (ERR_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] pat;
    logic       lvl;
    logic [1:0] quad [3];
    int         exp_err;

    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b0;
    bus.sample_tick = 1'b1;
    bus.a_raw       = 1'b0;
    bus.b_raw       = 1'b0;
    pat             = 6'b111101;
    quad[0]         = 2'b11;
    quad[1]         = 2'b01;
    quad[2]         = 2'b00;

    // Reset, then bring both channels high so state is non-zero.
    repeat (3) step();
    reset     = 1'b1;
    bus.a_raw = 1'b1;
    bus.b_raw = 1'b1;
    repeat (10) step();
    chk("pre_reset_a", 32'(bus.a), 32'd1);
    chk("pre_reset_err", 32'(bus.err_count), 32'd1);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    #3 reset = 1'b0;
    #1;
    chk("async_rst_a", 32'(bus.a), 32'd0);
    chk("async_rst_b", 32'(bus.b), 32'd0);
    chk("async_rst_illegal", 32'(bus.illegal), 32'd0);
    chk("async_rst_err", 32'(bus.err_count), 32'd0);
    chk("async_rst_cnt_a", 32'(dut.cnt_a), 32'd0);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("rel_a", 32'(bus.a), 32'(e >= int'(LAT)));
      chk("rel_b", 32'(bus.b), 32'(e >= int'(LAT)));
      chk("rel_illegal", 32'(bus.illegal), 32'(e == int'(LAT)));
      chk("rel_err", 32'(bus.err_count), 32'(e >= int'(LAT)));
    end

    // Latency: A falls exactly LAT edges after capture; B and illegal unaffected.
    bus.a_raw = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("lat_a", 32'(bus.a), 32'(e < int'(LAT)));
      chk("lat_b", 32'(bus.b), 32'd1);
      chk("lat_illegal", 32'(bus.illegal), 32'd0);
    end
    repeat (4) step();

    // Glitch: three captured highs never qualify; counter peaks at 3 then clears.
    for (int e = 1; e <= 10; e++) begin
      bus.a_raw = (e <= 3);
      step();
      chk("glitch_a", 32'(bus.a), 32'd0);
      if (e == 5) chk("glitch_cnt_peak", 32'(dut.cnt_a), 32'd3);
      if (e == 6) chk("glitch_cnt_clr", 32'(dut.cnt_a), 32'd0);
    end

    // Bounce 1,0,1,1,1,1: A rises on the 8th edge.
    for (int i = 0; i < 8; i++) begin
      bus.a_raw = (i < 6) ? pat[i] : 1'b1;
      step();
      chk("bounce_a", 32'(bus.a), 32'(i == 7));
    end
    repeat (3) step();

    // Simultaneous toggle 11 -> 00: one illegal pulse, count 1 -> 2.
    bus.a_raw = 1'b0;
    bus.b_raw = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("viol_a", 32'(bus.a), 32'(e < int'(LAT)));
      chk("viol_b", 32'(bus.b), 32'(e < int'(LAT)));
      chk("viol_illegal", 32'(bus.illegal), 32'(e == int'(LAT)));
      chk("viol_err", 32'(bus.err_count), (e >= int'(LAT)) ? 32'd2 : 32'd1);
    end
    repeat (3) step();

    // Tick every 4th clock: A rises on the 4th qualifying tick, counter holds between.
    bus.a_raw = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      bus.sample_tick = (k % 4 == 0);
      step();
      chk("tick_a", 32'(bus.a), 32'(k >= 16));
      chk("tick_cnt_a", 32'(dut.cnt_a), (k < 16) ? 32'(k / 4) : 32'd0);
      chk("tick_illegal", 32'(bus.illegal), 32'd0);
    end
    bus.sample_tick = 1'b1;
    repeat (4) step();

    // Legal quadrature walk 10 -> 11 -> 01 -> 00 at 10-clock spacing.
    for (int s = 0; s < 3; s++) begin
      bus.a_raw = quad[s][1];
      bus.b_raw = quad[s][0];
      for (int e = 1; e <= 10; e++) begin
        step();
        chk("quad_illegal", 32'(bus.illegal), 32'd0);
      end
      chk("quad_a", 32'(bus.a), 32'(quad[s][1]));
      chk("quad_b", 32'(bus.b), 32'(quad[s][0]));
    end
    chk("quad_err", 32'(bus.err_count), 32'd2);

    // Reset mid-qualification: progress is discarded and A needs a full LAT again.
    bus.a_raw = 1'b1;
    repeat (4) step();
    chk("midq_cnt_a", 32'(dut.cnt_a), 32'd2);
    #3 reset = 1'b0;
    #1;
    chk("midq_rst_cnt_a", 32'(dut.cnt_a), 32'd0);
    chk("midq_rst_err", 32'(bus.err_count), 32'd0);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("midq_a", 32'(bus.a), 32'(e >= int'(LAT)));
      chk("midq_illegal", 32'(bus.illegal), 32'd0);
    end
    bus.a_raw = 1'b0;
    repeat (8) step();
    chk("midq_settle_a", 32'(bus.a), 32'd0);

    // Saturation: five simultaneous toggles read 1,2,3,3,3 with a pulse each time.
    for (int n = 1; n <= 5; n++) begin
      lvl       = n[0];
      bus.a_raw = lvl;
      bus.b_raw = lvl;
      exp_err   = (n < 3) ? n : 3;
      for (int e = 1; e <= 10; e++) begin
        step();
        if (e == int'(LAT)) begin
          chk("sat_illegal_hi", 32'(bus.illegal), 32'd1);
          chk("sat_err", 32'(bus.err_count), 32'(exp_err));
          chk("sat_a", 32'(bus.a), 32'(lvl));
        end
        if (e == int'(LAT) + 1) chk("sat_illegal_lo", 32'(bus.illegal), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quadrature_debouncer.md
Name: quadrature_debouncer

Overview:
Input conditioner for a quadrature rotary encoder. It sits directly upstream of the quadrature decoder/counter stage. It takes raw, asynchronous, bouncy A/B pin levels and produces synchronized, debounced channel levels that the decoder samples every clock. It also flags quadrature violations, where both channels change on the same cycle, because the decoder cannot count those.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per channel; minimum 2.
DEBOUNCE_CYCLES, 16, consecutive qualifying sample ticks a new level must persist before it is accepted; legal range 1..2^CNT_WIDTH-1.
CNT_WIDTH, 16, width of each per-channel debounce counter.
ERR_WIDTH, 8, width of the saturating violation counter.

Ports:
clk  input  1  system clock; all flops on rising edge.
reset  input  1  asynchronous, active-low reset; asserted when 0.
sample_tick  input  1  debounce qualifier; debounce logic advances only on clocks where this is 1. Tie high to advance every clock.
a_raw  input  1  raw encoder channel A; asynchronous to clk.
b_raw  input  1  raw encoder channel B; asynchronous to clk.
a  output  1  debounced channel A, registered.
b  output  1  debounced channel B, registered.
illegal  output  1  one-cycle pulse: a and b both changed on the same edge.
err_count  output  ERR_WIDTH  count of illegal pulses since reset; saturates.

Behaviour:
- Reset (reset=0, asynchronous):
  - all synchronizer flops, a, b, illegal, err_count and both debounce counters go to 0 immediately.
  - Release takes effect at the next rising edge; no reset synchronizer inside the block.
- Synchronizer: per channel, a shift chain of SYNC_STAGES flops, shifting every clock regardless of sample_tick. Let sa/sb denote the last stage.
- Debounce, per channel (shown for A; B is identical and independent), evaluated at each rising edge with sample_tick=1:
  - sa == a: cnt_a <= 0; a holds.
  - sa != a and cnt_a == DEBOUNCE_CYCLES-1: a <= sa; cnt_a <= 0.
  - sa != a otherwise: cnt_a <= cnt_a+1.
- With sample_tick=0, counters and outputs hold and do not clear.
- Any tick on which sa matches a restarts qualification. A pulse shorter than DEBOUNCE_CYCLES ticks never reaches the output.
- Latency with sample_tick tied high: a stable raw transition reaches the output at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after it is first captured.
- DEBOUNCE_CYCLES=1: output follows the synchronizer with one extra register delay.
- Violation detect:
  - illegal <= 1 for exactly one cycle when a and b both toggle at the same edge; otherwise 0.
  - On each such cycle, err_count <= err_count+1, unless already all-ones, in which case it holds.
- A single-channel toggle never sets illegal.
- No internal state leaves a/b in an intermediate value; outputs are always clean registered levels.
- Counter arithmetic is unsigned. The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap can occur.

Test Plan:
1. Reset: drive a_raw=b_raw=1, pulse reset low mid-cycle -> a=b=illegal=0 and err_count=0 immediately, without a clock edge. After release with tick high, a and b go to 1 at edge SYNC_STAGES+DEBOUNCE_CYCLES.
2. Latency (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, tick=1): a_raw 0->1 held -> a=1 exactly 6 edges after capture; b unchanged; illegal stays 0.
3. Glitch rejection (same params): a_raw high for 3 clocks then low -> a never leaves 0. Bounce pattern 1,0,1,1,1,1 -> a rises 4 ticks after the last 0 clears through the synchronizer.
4. Tick gating: sample_tick pulsed every 4th clock, DEBOUNCE_CYCLES=4, a_raw held high -> a rises on the 4th qualifying tick. Counter holds between ticks: probe cnt_a, or infer it from rise time.
5. Violation: a_raw and b_raw toggled on the same clock and held -> a and b change on the same edge; illegal=1 for exactly one cycle; err_count 0->1. A quadrature sequence 00->10->11->01->00 with 10-clock spacing -> illegal never asserts.
6. Saturation (ERR_WIDTH=2): 5 simultaneous toggles -> err_count reads 1, 2, 3, 3, 3; illegal still pulses each time. Asserting reset mid-qualification clears the count and the qualification does not complete.
